pipe_mux_rr: RTL and testbench
==============================

// Module: pipe_mux_rr
// PURPOSE
//   Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshake.
//   Next generation of the datapath 4:1 select mux: any input count, one output register
//   stage, backpressure, and a run-time round-robin mode for sharing one sink between sources.
//   Sits between multiple producers (e.g. ALU/memory/PC-next sources) and one consumer stage.
// PARAMETERS
//   N      4   number of input channels; legal range N >= 2
//   WIDTH  32  data width per channel
//   SELW   derived localparam = $clog2(N); not overridable
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous, active-low reset
//   in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid   in   N        per-channel valid
//   in_ready   out  N        per-channel ready; combinational
//   sel        in   SELW     channel select in fixed mode
//   rr_mode    in   1        0 = fixed select via sel; 1 = round-robin among valid channels
//   out_data   out  WIDTH    registered output data
//   out_src    out  SELW     index of the channel that produced out_data
//   out_valid  out  1        registered output valid
//   out_ready  in   1        downstream ready
// BEHAVIOUR
// - Reset (async, rst_n=0): out_valid=0, out_data=0, out_src=0, rr pointer last=N-1.
//   Reset deasserts synchronously to clk externally. Reset mid-transfer drops the held word.
// - can_load = !out_valid || out_ready. The output register loads when can_load is high.
// - Grant is one-hot g[N-1:0], computed combinationally every cycle.
//   - Fixed mode: g[sel]=1 when sel<N. When sel>=N, g=0 and nothing is accepted.
//   - RR mode: g selects the first valid channel scanning last+1, last+2, ... with mod-N wrap.
//     When no channel is valid, g=0.
// - in_ready[i] = can_load && g[i]. At most one in_ready is high per cycle.
//   In fixed mode, in_ready[sel] may be high while in_valid[sel]=0.
// - Transfer occurs on channel k when in_valid[k] && in_ready[k].
//   At the next edge: out_data<=in_data[k], out_src<=k, out_valid<=1.
//   In RR mode only, the next edge also sets last<=k.
// - If can_load is high and no transfer occurs, out_valid<=0. out_data and out_src hold.
// - Stall: while out_valid && !out_ready, out_data and out_src are held stable and all in_ready=0.
// - Latency: 1 cycle from input accept to out_valid.
//   Throughput is 1 word per cycle when out_ready is held high.
// - sel and rr_mode are not latched; a change takes effect on the same cycle's grant.
//   The rr pointer is kept across mode switches and is updated only by RR-mode transfers.
// - No combinational path exists from in_data to out_data.
//   Combinational paths to in_ready: out_ready, sel, rr_mode, in_valid.
// - N not a power of two: the pointer wraps from N-1 to 0, and sel values >= N are ignored.
// CONFIGURATION
// - PIPE_MUX_PARITY_EN defined: adds output port out_parity (1 bit), registered with out_data.
//   out_parity = ^in_data[k] of the accepted word (even parity). Reset value 0.
//   It holds together with out_data.
// - PIPE_MUX_PARITY_EN undefined: the port and its register are absent; all other behaviour is identical.
// TESTING
// 1 Fixed mode, N=4, W=32: in_data ch0..3 = 1,2,4,8; all in_valid=1, out_ready=1; sel=0,1,2,3
//   on consecutive cycles -> out_data = 1,2,4,8 one cycle later; out_src = 0,1,2,3.
// 2 Backpressure: accept 0xA5A5A5A5 from ch2, then out_ready=0 for 3 cycles -> out_data held,
//   out_valid=1, in_ready=0000; out_ready=1 -> word consumed, next word loads the same cycle.
// 3 RR mode, all 4 channels valid, out_ready=1 from reset -> out_src = 0,1,2,3,0,1; one word per cycle.
// 4 RR skip/wrap: only ch1 and ch3 valid, last=3 -> grants 1,3,1,3; no channels valid -> out_valid=0
//   the cycle after the last word drains.
// 5 Edge cases: fixed mode with sel=3 on N=3 -> in_ready=000 and no load; assert rst_n=0 while
//   out_valid=1 -> out_valid=0 and out_data=0 immediately, with no clk edge required.
// 6 PIPE_MUX_PARITY_EN: accept 0x00000007 -> out_parity=1; accept 0x00000003 -> out_parity=0.

Source files
------------

// File: rtl/pipe_mux_rr.sv
// N-input registered mux with valid/ready handshake and run-time fixed/round-robin grant.
// Optional out_parity output (even parity of out_data) enabled by defining PIPE_MUX_PARITY_EN.
module pipe_mux_rr #(
   parameter int N = 4,
   parameter int WIDTH = 32,
   localparam int SELW = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   input  logic               rr_mode,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_src,
   output logic               out_valid,
   input  logic               out_ready
`ifdef PIPE_MUX_PARITY_EN
   ,
   output logic               out_parity
`endif
);

`ifdef PIPE_MUX_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction
`endif

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_src_q, out_src_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  last_q, last_d;
`ifdef PIPE_MUX_PARITY_EN
   logic             out_parity_q, out_parity_d;
`endif

   logic             can_load_s;
   logic             sel_ok_s;
   logic [N-1:0]     fix_grant_s;
   logic [N-1:0]     rr_grant_s;
   logic [N-1:0]     grant_s;
   logic [N-1:0]     in_ready_s;
   logic             found_s;
   logic [SELW-1:0]  scan_idx_s;
   logic [WIDTH-1:0] data_sel_s;
   logic [SELW-1:0]  grant_idx_s;
   logic             xfer_s;

   // Only a non-power-of-two N can present a sel value with no matching channel.
   generate
      if ((N & (N - 32'sd1)) == 32'sd0) begin : g_sel_pow2
         assign sel_ok_s = 1'b1;
      end else begin : g_sel_np2
         assign sel_ok_s = (sel < SELW'(N));
      end
   endgenerate

   assign can_load_s = !out_valid_q || out_ready;

   // Fixed-mode grant from sel.
   always_comb begin
      fix_grant_s = '0;
      if (sel_ok_s) begin
         fix_grant_s[sel] = 1'b1;
      end else begin
         fix_grant_s = '0;
      end
   end

   // Round-robin grant: first valid channel after last, wrapping modulo N.
   always_comb begin
      rr_grant_s = '0;
      found_s    = 1'b0;
      scan_idx_s = '0;
      for (int off = 1; off <= N; off++) begin
         scan_idx_s = SELW'((int'(last_q) + off) % N);
         if (!found_s && in_valid[scan_idx_s]) begin
            rr_grant_s[scan_idx_s] = 1'b1;
            found_s                = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign grant_s    = rr_mode ? rr_grant_s : fix_grant_s;
   assign in_ready_s = grant_s & {N{can_load_s}};
   assign xfer_s     = |(in_valid & in_ready_s);

   // One-hot grant makes an AND-OR mux and index encoder sufficient.
   always_comb begin
      data_sel_s  = '0;
      grant_idx_s = '0;
      for (int i = 0; i < N; i++) begin
         data_sel_s  = data_sel_s  | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
         grant_idx_s = grant_idx_s | (SELW'(i) & {SELW{grant_s[i]}});
      end
   end

   // Next-state for the output stage and rr pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      last_d      = last_q;
`ifdef PIPE_MUX_PARITY_EN
      out_parity_d = out_parity_q;
`endif
      if (can_load_s) begin
         if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = data_sel_s;
            out_src_d   = grant_idx_s;
`ifdef PIPE_MUX_PARITY_EN
            out_parity_d = even_parity(data_sel_s);
`endif
            if (rr_mode) begin
               last_d = grant_idx_s;
            end else begin
               last_d = last_q;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register and rr pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         last_q      <= SELW'(N - 1);
`ifdef PIPE_MUX_PARITY_EN
         out_parity_q <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         last_q      <= last_d;
`ifdef PIPE_MUX_PARITY_EN
         out_parity_q <= out_parity_d;
`endif
      end
   end

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;
`ifdef PIPE_MUX_PARITY_EN
   assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_pipe_mux_rr.sv
// Directed self-checking bench for pipe_mux_rr: an N=4 instance for the main scenarios
// and an N=3 instance for non-power-of-two select and pointer wrap.
module tb_pipe_mux_rr;

   logic         clk;
   logic         rst_n;

   logic [127:0] in_data;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [1:0]   sel;
   logic         rr_mode;
   logic [31:0]  out_data;
   logic [1:0]   out_src;
   logic         out_valid;
   logic         out_ready;

   logic [95:0]  in_data3;
   logic [2:0]   in_valid3;
   logic [2:0]   in_ready3;
   logic [1:0]   sel3;
   logic         rr_mode3;
   logic [31:0]  out_data3;
   logic [1:0]   out_src3;
   logic         out_valid3;
   logic         out_ready3;

`ifdef PIPE_MUX_PARITY_EN
   logic         out_parity;
   logic         out_parity3;
`endif

   int tests_run;
   int tests_failed;

   pipe_mux_rr #(.N(4), .WIDTH(32)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .rr_mode(rr_mode),
      .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
`ifdef PIPE_MUX_PARITY_EN
      , .out_parity(out_parity)
`endif
   );

   pipe_mux_rr #(.N(3), .WIDTH(32)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .sel(sel3), .rr_mode(rr_mode3),
      .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef PIPE_MUX_PARITY_EN
      , .out_parity(out_parity3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_data = '0; in_valid = 4'b0000; sel = 2'd0; rr_mode = 1'b0; out_ready = 1'b1;
      #2;
      tests_run++;
      if (out_valid !== 1'b0 || out_data !== 32'd0 || out_src !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_state: valid=%b data=%h src=%0d, required 0/0/0", out_valid, out_data, out_src);
      end
      tests_run++;
      if (in_ready !== 4'b0001) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b, required 0001", in_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_after_reset: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_fixed();
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'd1 << i;
      in_valid = 4'b1111; out_ready = 1'b1; rr_mode = 1'b0;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         tick();
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== (32'd1 << s) || out_src !== 2'(s)) begin
            tests_failed++;
            $display("FAIL fixed_sel%0d: valid=%b data=%h src=%0d, required 1/%h/%0d",
                     s, out_valid, out_data, out_src, 32'd1 << s, s);
         end
      end
      in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      rr_mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
      in_data[64 +: 32] = 32'hA5A5A5A5;
      in_valid = 4'b0100;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || out_src !== 2'd2) begin
         tests_failed++;
         $display("FAIL bp_accept: valid=%b data=%h src=%0d, required 1/a5a5a5a5/2", out_valid, out_data, out_src);
      end
      out_ready = 1'b0;
      in_data[64 +: 32] = 32'h12345678;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bp_ready_c%0d: in_ready=%b, required 0000", c, in_ready);
         end
         tick();
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || out_src !== 2'd2) begin
            tests_failed++;
            $display("FAIL bp_hold_c%0d: valid=%b data=%h src=%0d, required 1/a5a5a5a5/2",
                     c, out_valid, out_data, out_src);
         end
      end
      out_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 4'b0100) begin
         tests_failed++;
         $display("FAIL bp_release_ready: in_ready=%b, required 0100", in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin
         tests_failed++;
         $display("FAIL bp_next_word: valid=%b data=%h, required 1/12345678", out_valid, out_data);
      end
      in_valid = 4'b0000;
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || out_data !== 32'h12345678 || out_src !== 2'd2) begin
         tests_failed++;
         $display("FAIL bp_drain: valid=%b data=%h src=%0d, required 0/12345678/2", out_valid, out_data, out_src);
      end
   endtask

   task automatic test_rr_all();
      logic [1:0] exp_src [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      in_valid = 4'b0000; rr_mode = 1'b1; out_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h100 + 32'(i);
      in_valid = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b1 || out_src !== exp_src[c] || out_data !== (32'h100 + 32'(exp_src[c]))) begin
            tests_failed++;
            $display("FAIL rr_all_c%0d: valid=%b src=%0d data=%h, required 1/%0d/%h",
                     c, out_valid, out_src, out_data, exp_src[c], 32'h100 + 32'(exp_src[c]));
         end
      end
      in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_rr_skip_wrap();
      logic [1:0] exp_src [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
      rr_mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0000;
      do_reset();
      in_valid = 4'b1010;
      for (int c = 0; c < 4; c++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b1 || out_src !== exp_src[c]) begin
            tests_failed++;
            $display("FAIL rr_skip_c%0d: valid=%b src=%0d, required 1/%0d", c, out_valid, out_src, exp_src[c]);
         end
      end
      in_valid = 4'b0000;
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || out_src !== 2'd3) begin
         tests_failed++;
         $display("FAIL rr_drain: valid=%b src=%0d, required 0/3", out_valid, out_src);
      end
   endtask

   // Pointer is 3 here; a fixed-mode transfer from ch0 must not move it.
   task automatic test_mode_switch();
      rr_mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
      tick();
      rr_mode = 1'b1; in_valid = 4'b1111;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_src !== 2'd0) begin
         tests_failed++;
         $display("FAIL mode_switch_ptr: valid=%b src=%0d, required 1/0", out_valid, out_src);
      end
      in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_edge_cases();
      for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'h30 + 32'(i);
      in_valid3 = 3'b111; out_ready3 = 1'b1; rr_mode3 = 1'b0; sel3 = 2'd3;
      #1;
      tests_run++;
      if (in_ready3 !== 3'b000) begin
         tests_failed++;
         $display("FAIL n3_sel3_ready: in_ready=%b, required 000", in_ready3);
      end
      tick();
      tests_run++;
      if (out_valid3 !== 1'b0) begin
         tests_failed++;
         $display("FAIL n3_sel3_noload: out_valid=%b, required 0", out_valid3);
      end
      rr_mode3 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         tests_run++;
         if (out_valid3 !== 1'b1 || out_src3 !== 2'(c % 3) || out_data3 !== (32'h30 + 32'(c % 3))) begin
            tests_failed++;
            $display("FAIL n3_rr_wrap_c%0d: valid=%b src=%0d data=%h, required 1/%0d/%h",
                     c, out_valid3, out_src3, out_data3, c % 3, 32'h30 + 32'(c % 3));
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid3 !== 1'b0 || out_data3 !== 32'd0 || out_src3 !== 2'd0) begin
         tests_failed++;
         $display("FAIL async_reset: valid=%b data=%h src=%0d, required 0/0/0", out_valid3, out_data3, out_src3);
      end
      in_valid3 = 3'b000;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

`ifdef PIPE_MUX_PARITY_EN
   task automatic test_parity();
      rr_mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
      in_data[32 +: 32] = 32'h00000007;
      in_valid = 4'b0010;
      tick();
      tests_run++;
      if (out_parity !== 1'b1 || out_data !== 32'h7) begin
         tests_failed++;
         $display("FAIL parity_7: parity=%b data=%h, required 1/00000007", out_parity, out_data);
      end
      in_data[32 +: 32] = 32'h00000003;
      tick();
      tests_run++;
      if (out_parity !== 1'b0 || out_data !== 32'h3) begin
         tests_failed++;
         $display("FAIL parity_3: parity=%b data=%h, required 0/00000003", out_parity, out_data);
      end
      in_valid = 4'b0000;
      tick();
   endtask
`endif

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      in_data = '0; in_valid = '0; sel = '0; rr_mode = 1'b0; out_ready = 1'b1;
      in_data3 = '0; in_valid3 = '0; sel3 = '0; rr_mode3 = 1'b0; out_ready3 = 1'b1;
      #1;
      test_reset();
      test_fixed();
      test_backpressure();
      test_rr_all();
      test_rr_skip_wrap();
      test_mode_switch();
      test_edge_cases();
`ifdef PIPE_MUX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
